// File: rtl/avalon_capture_pio_pkg.sv
// Shared constants for the capture PIO: register map, status bit positions
// and edge-detect encodings.
package avalon_capture_pio_pkg;

  localparam logic [2:0] ADDR_DATA        = 3'd0;
  localparam logic [2:0] ADDR_IRQMASK     = 3'd1;
  localparam logic [2:0] ADDR_EDGECAP     = 3'd2;
  localparam logic [2:0] ADDR_FIFO_DATA   = 3'd3;
  localparam logic [2:0] ADDR_FIFO_STATUS = 3'd4;

  localparam int STATUS_OVF_BIT    = 31;
  localparam int STATUS_CLR_BIT    = 30;
  localparam int STATUS_IRQ_EN_BIT = 29;
  localparam int LEVEL_W           = 9;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/avalon_capture_pio_capture_sample_fifo.sv
// Circular sample buffer with wrap-bit pointers, sticky overflow and flush.
module capture_sample_fifo
  import avalon_capture_pio_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic               clr_overflow,
  input  logic [DATA_W-1:0]  wdata,
  output logic [DATA_W-1:0]  rdata,
  output logic               empty,
  output logic               full,
  output logic [LEVEL_W-1:0] level,
  output logic               overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
  logic [AW:0]       wr_ptr_r;
  logic [AW:0]       rd_ptr_r;
  logic              overflow_r;
  logic              do_push_s;
  logic              do_pop_s;

  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign do_pop_s  = pop && !empty;
  // A full FIFO still accepts a sample when a pop frees a slot in the same cycle.
  assign do_push_s = push && (!full || do_pop_s);
  assign level     = LEVEL_W'(wr_ptr_r - rd_ptr_r);
  assign rdata     = mem_r[rd_ptr_r[AW-1:0]];
  assign overflow  = overflow_r;

  // Sample storage, left unreset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (do_push_s && !flush) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wdata;
    end
  end

  // Pointer update; flush takes priority over any push or pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
    end
  end

  // Sticky overflow: a dropped sample beats a clear in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_r <= 1'b0;
    end else if (push && full && !do_pop_s && !flush) begin
      overflow_r <= 1'b1;
    end else if (clr_overflow) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= overflow_r;
    end
  end

endmodule

// File: rtl/avalon_capture_pio.sv
// Avalon-MM input port: synchronised data, per-bit edge capture with mask,
// and a strobe-loaded sample FIFO with threshold interrupt.
module avalon_capture_pio
  import avalon_capture_pio_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 0,
  parameter int FIFO_DEPTH  = 16,
  parameter int FIFO_THRESH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [DATA_W-1:0] in_port,
  input  logic              sample_valid,
  output logic              irq
);

  logic [DATA_W-1:0]  data_s;
  logic [DATA_W-1:0]  prev_r;
  logic [DATA_W-1:0]  edge_s;
  logic [DATA_W-1:0]  irq_mask_r;
  logic [DATA_W-1:0]  edge_capture_r;
  logic [DATA_W-1:0]  w1c_s;
  logic               fifo_irq_en_r;
  logic [31:0]        rd_mux_s;
  logic [31:0]        readdata_r;
  logic               irq_r;
  logic               status_wr_s;
  logic               fifo_pop_s;
  logic [DATA_W-1:0]  fifo_rdata_s;
  logic               fifo_empty_s;
  logic               fifo_full_s;
  logic [LEVEL_W-1:0] fifo_level_s;
  logic               fifo_ovf_s;
  logic               unused_s;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign data_s = in_port;
    end else begin : g_sync
      logic [DATA_W-1:0] sync_r [SYNC_STAGES];
      // Input synchroniser chain.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= {DATA_W{1'b0}};
        end else begin
          sync_r[0] <= in_port;
          for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
        end
      end
      assign data_s = sync_r[SYNC_STAGES-1];
    end
  endgenerate

  assign status_wr_s = write && (address == ADDR_FIFO_STATUS);
  assign fifo_pop_s  = read && (address == ADDR_FIFO_DATA);
  assign w1c_s       = (write && (address == ADDR_EDGECAP)) ? writedata[DATA_W-1:0]
                                                            : {DATA_W{1'b0}};
  assign unused_s    = ^writedata;

  // Edge qualification against the delayed copy of the synchronised input.
  always_comb begin
    edge_s = {DATA_W{1'b0}};
    case (EDGE_MODE)
      EDGE_FALL: edge_s = ~data_s & prev_r;
      EDGE_ANY:  edge_s = data_s ^ prev_r;
      default:   edge_s = data_s & ~prev_r;
    endcase
  end

  // Control registers; a new edge overrides a W1C on the same bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_r         <= {DATA_W{1'b0}};
      irq_mask_r     <= {DATA_W{1'b0}};
      edge_capture_r <= {DATA_W{1'b0}};
      fifo_irq_en_r  <= 1'b0;
    end else begin
      prev_r         <= data_s;
      edge_capture_r <= (edge_capture_r & ~w1c_s) | edge_s;
      if (write && (address == ADDR_IRQMASK)) irq_mask_r <= writedata[DATA_W-1:0];
      if (status_wr_s) fifo_irq_en_r <= writedata[STATUS_IRQ_EN_BIT];
    end
  end

  // Read mux; zero whenever read is low or the address is unmapped.
  always_comb begin
    rd_mux_s = 32'd0;
    if (read) begin
      case (address)
        ADDR_DATA:      rd_mux_s[DATA_W-1:0] = data_s;
        ADDR_IRQMASK:   rd_mux_s[DATA_W-1:0] = irq_mask_r;
        ADDR_EDGECAP:   rd_mux_s[DATA_W-1:0] = edge_capture_r;
        ADDR_FIFO_DATA: begin
          if (!fifo_empty_s) rd_mux_s[DATA_W-1:0] = fifo_rdata_s;
          else               rd_mux_s = 32'd0;
        end
        ADDR_FIFO_STATUS: begin
          rd_mux_s[STATUS_OVF_BIT]    = fifo_ovf_s;
          rd_mux_s[STATUS_IRQ_EN_BIT] = fifo_irq_en_r;
          rd_mux_s[LEVEL_W-1:0]       = fifo_level_s;
        end
        default:        rd_mux_s = 32'd0;
      endcase
    end else begin
      rd_mux_s = 32'd0;
    end
  end

  // Registered read data and interrupt.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_r <= 32'd0;
      irq_r      <= 1'b0;
    end else begin
      readdata_r <= rd_mux_s;
      irq_r      <= (|(edge_capture_r & irq_mask_r)) ||
                    (fifo_irq_en_r && (fifo_level_s >= LEVEL_W'(FIFO_THRESH)));
    end
  end

  assign readdata = readdata_r;
  assign irq      = irq_r;

  capture_sample_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset_n      (reset_n),
    .push         (sample_valid),
    .pop          (fifo_pop_s),
    .flush        (status_wr_s && writedata[STATUS_OVF_BIT]),
    .clr_overflow (status_wr_s && writedata[STATUS_CLR_BIT]),
    .wdata        (in_port),
    .rdata        (fifo_rdata_s),
    .empty        (fifo_empty_s),
    .full         (fifo_full_s),
    .level        (fifo_level_s),
    .overflow     (fifo_ovf_s)
  );

endmodule

// File: tb/tb_avalon_capture_pio.sv
// Scoreboard bench for avalon_capture_pio: reads queue expected readdata,
// a negedge monitor pops and compares one cycle after each sampled read.
module tb_avalon_capture_pio;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [15:0] in_port = 16'hA5A5;
  logic        sample_valid = 1'b0;
  logic        irq;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic        rd_seen = 1'b0;

  avalon_capture_pio #(
    .DATA_W(16), .SYNC_STAGES(2), .EDGE_MODE(0), .FIFO_DEPTH(16), .FIFO_THRESH(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .in_port(in_port),
    .sample_valid(sample_valid), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_seen <= 1'b0;
    else          rd_seen <= read;
  end

  // Monitor: each sampled read must match the next queued expectation.
  always @(negedge clk) begin
    if (rd_seen) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_read: readdata=%h with nothing expected", readdata);
      end else begin
        logic [31:0] e;
        string       n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if (readdata !== e) begin
          miscompares++;
          $display("FAIL %s: readdata=%h expected=%h", n, readdata, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got=%h expected=%h", n, act, exp);
    end
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e, input string n);
    address = a;
    read = 1'b1;
    exp_q.push_back(e);
    name_q.push_back(n);
    tick();
    read = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a;
    writedata = d;
    write = 1'b1;
    tick();
    write = 1'b0;
  endtask

  task automatic push(input logic [15:0] v);
    in_port = v;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("reset_readdata", readdata, 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Synchroniser latency on DATA
    rd(3'd0, 32'h0000_0000, "data_before_sync");
    tick();
    tick();
    rd(3'd0, 32'h0000_A5A5, "data_synced");
    rd(3'd2, 32'h0000_A5A5, "edgecap_multi_bit");
    in_port = 16'h0000;
    repeat (4) tick();
    wr(3'd2, 32'h0000_FFFF);
    rd(3'd2, 32'h0000_0000, "edgecap_cleared");
    rd(3'd5, 32'h0000_0000, "unmapped_addr");

    // Rising edge capture and interrupt
    wr(3'd1, 32'h0000_0001);
    rd(3'd1, 32'h0000_0001, "irqmask_rw");
    in_port = 16'h0001;
    repeat (5) tick();
    check("irq_on_edge", {31'd0, irq}, 32'd1);
    rd(3'd2, 32'h0000_0001, "edgecap_bit0");
    wr(3'd2, 32'h0000_0001);
    tick();
    check("irq_after_w1c", {31'd0, irq}, 32'd0);
    rd(3'd2, 32'h0000_0000, "edgecap_w1c");

    // Edge and W1C on the same bit in the same cycle: set wins
    in_port = 16'h0000;
    repeat (4) tick();
    in_port = 16'h0001;
    tick();
    tick();
    wr(3'd2, 32'h0000_0001);
    rd(3'd2, 32'h0000_0001, "edgecap_set_wins");
    wr(3'd2, 32'h0000_0001);
    rd(3'd2, 32'h0000_0000, "edgecap_w1c2");
    wr(3'd1, 32'h0000_0000);

    // Basic FIFO ordering and empty read
    push(16'd1);
    push(16'd2);
    push(16'd3);
    rd(3'd4, 32'h0000_0003, "level_3");
    rd(3'd3, 32'h0000_0001, "fifo_pop1");
    rd(3'd3, 32'h0000_0002, "fifo_pop2");
    rd(3'd3, 32'h0000_0003, "fifo_pop3");
    rd(3'd3, 32'h0000_0000, "fifo_empty_read");
    rd(3'd4, 32'h0000_0000, "level_0");

    // Overflow, clear, push+pop while full
    for (int i = 1; i <= 17; i++) push(16'(i));
    rd(3'd4, 32'h8000_0010, "full_overflow");
    rd(3'd3, 32'h0000_0001, "first_after_ovf");
    wr(3'd4, 32'h4000_0000);
    rd(3'd4, 32'h0000_000F, "ovf_cleared");
    push(16'd18);
    rd(3'd4, 32'h0000_0010, "full_again");
    address = 3'd3;
    read = 1'b1;
    in_port = 16'd19;
    sample_valid = 1'b1;
    exp_q.push_back(32'h0000_0002);
    name_q.push_back("push_pop_full");
    tick();
    read = 1'b0;
    sample_valid = 1'b0;
    rd(3'd4, 32'h0000_0010, "full_no_ovf");

    // Flush wins over a coincident sample
    address = 3'd4;
    writedata = 32'h8000_0000;
    write = 1'b1;
    sample_valid = 1'b1;
    tick();
    write = 1'b0;
    sample_valid = 1'b0;
    rd(3'd4, 32'h0000_0000, "flush_level0");

    // FIFO threshold interrupt
    wr(3'd4, 32'h2000_0000);
    rd(3'd4, 32'h2000_0000, "irq_en_set");
    for (int i = 1; i <= 7; i++) push(16'h0100 + 16'(i));
    tick();
    check("irq_level7", {31'd0, irq}, 32'd0);
    push(16'h0108);
    check("irq_level8_same_cycle", {31'd0, irq}, 32'd0);
    tick();
    check("irq_level8", {31'd0, irq}, 32'd1);
    rd(3'd3, 32'h0000_0101, "thresh_pop");
    tick();
    check("irq_after_pop", {31'd0, irq}, 32'd0);
    push(16'h0109);
    tick();

    // Asynchronous reset mid-operation
    address = 3'd4;
    read = 1'b1;
    exp_q.push_back(32'h2000_0008);
    name_q.push_back("status_before_reset");
    @(posedge clk);
    @(negedge clk);
    #1;
    check("irq_before_reset", {31'd0, irq}, 32'd1);
    reset_n = 1'b0;
    read = 1'b0;
    #1;
    check("readdata_in_reset", readdata, 32'd0);
    check("irq_in_reset", {31'd0, irq}, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    rd(3'd4, 32'h0000_0000, "status_after_reset");
    rd(3'd3, 32'h0000_0000, "fifo_after_reset");

    repeat (3) tick();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected reads never observed", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/avalon_capture_pio.md
Name: avalon_capture_pio

Overview:
- Parametrised Avalon-MM slave input port for NIOS; successor to the fixed 16-bit, read-only input PIO.
- Adds:
  - selectable input width and configurable input synchroniser;
  - per-bit edge capture with interrupt mask;
  - a sample FIFO that buffers in_port words on an external strobe, so the CPU can drain acquisition data in bursts.
- Sits between acquisition logic (ultrasonic front end) and the NIOS data master.

Parameters:
- DATA_W, 16: input width, 1..32; readdata zero-extended to 32.
- SYNC_STAGES, 2: flops on in_port before the DATA/edge path; 0 = bypass.
- EDGE_MODE, 0: 0 rising, 1 falling, 2 any edge.
- FIFO_DEPTH, 16: sample FIFO entries, power of two, 2..256.
- FIFO_THRESH, 8: FIFO level at or above which the FIFO interrupt condition is true.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  3  register select
- read  in  1  Avalon read strobe
- write  in  1  Avalon write strobe
- writedata  in  32  write data
- readdata  out  32  registered read data
- in_port  in  DATA_W  external input word
- sample_valid  in  1  clk-synchronous strobe; pushes raw in_port into FIFO
- irq  out  1  level interrupt

Behaviour:
- Reset values (reset_n=0, async):
  - readdata=0, irq=0, sync flops=0, edge_capture=0, irq_mask=0;
  - FIFO empty, level=0, overflow=0, fifo_irq_en=0.
- Read latency: 1 cycle. readdata updates every clk from the mux of the current address, gated by read.
  - read=0: readdata=0.
  - Unused bits: 0.
  - Unmapped addresses: 0.
- Register map:
  - 0 DATA (RO): synchronised in_port.
  - 1 IRQMASK (RW, DATA_W bits).
  - 2 EDGECAP (read returns edge_capture; write = W1C per bit).
  - 3 FIFO_DATA (read returns head entry and pops).
  - 4 FIFO_STATUS:
    - Read: bit31 overflow, bit29 fifo_irq_en, bits[8:0] level.
    - Write: bit31=1 flush, bit30=1 clear overflow, bit29 sets fifo_irq_en.
  - Writes to 0, 3, 5-7 are ignored.
- Edge detect uses the last sync stage vs one extra delay flop. Detection sets edge_capture[i] per EDGE_MODE.
  - If set and a W1C to the same bit occur in the same cycle, set wins.
- irq is registered: irq <= |(edge_capture & irq_mask) | (fifo_irq_en & level>=FIFO_THRESH).
  - This adds 1 cycle after the causing register change.
- FIFO: circular buffer with log2(FIFO_DEPTH)+1-bit pointers; full = MSBs differ and LSBs equal.
  - Push on sample_valid. Pop on read with address==3 and not empty.
  - Read with address==3 while empty: readdata=0, no pointer change, no error flag.
  - Push while full with no simultaneous pop: sample dropped, overflow set (sticky).
  - Push and pop in same cycle while full: both occur, level unchanged, no overflow.
  - Push and pop in same cycle while empty: no pop; push occurs; readdata=0.
  - Flush empties the FIFO next cycle. If flush coincides with sample_valid, flush wins and the sample is discarded.
  - Pointer wrap at FIFO_DEPTH is transparent.
- Mid-operation reset clears everything immediately; no recovery of FIFO contents.
- FIFO storage is inferred RAM or registers. Read data comes from head combinationally, then registers into readdata.

Decomposition:
- Package avalon_capture_pio_pkg:
  - address constants ADDR_DATA=0 .. ADDR_FIFO_STATUS=4;
  - STATUS bit positions 31/30/29;
  - EDGE_MODE encodings.
- One sub-module: capture_sample_fifo.
  - Parameters: DATA_W, FIFO_DEPTH.
  - Ports: push, pop, flush, wdata, rdata, empty, full, level, overflow, clr_overflow.
  - The top level holds the sync chain, edge logic, register mux and irq.

Test Plan:
- Reset then read addr 0 with in_port=16'hA5A5, SYNC_STAGES=2 -> readdata=0 before sync; 32'h0000A5A5 once in_port has been stable 2 cycles, 1 cycle after read.
- EDGE_MODE=0, IRQMASK=1; in_port bit0 0->1 -> EDGECAP bit0=1, irq=1.
  - Then W1C 32'h1 -> EDGECAP=0, irq=0 next cycle.
  - Repeat with edge and W1C in the same cycle -> bit stays 1.
- Push 3 samples (1, 2, 3) -> STATUS level=3; three FIFO_DATA reads return 1, 2, 3; fourth read returns 0 and level stays 0.
- FIFO_DEPTH=16: push 17 samples -> level=16, overflow=1, first read returns sample 1.
  - Push+pop in same cycle while full -> level stays 16, no further overflow change.
  - Write STATUS bit30 -> overflow=0.
- fifo_irq_en=1, FIFO_THRESH=8: push 7 -> irq=0; push 8th -> irq=1 one cycle later; one pop -> irq=0.
- Flush with simultaneous sample_valid -> level=0 next cycle.
  - Assert reset_n=0 with FIFO half full -> readdata=0, irq=0, level=0 immediately.
